// File: rtl/dif_radix2_pkg.sv
// Shared types and helpers for the radix-2 DIF output reorder buffer.
// Holds the ping-pong bank state encoding, bit-reversal and length clamp.
package dif_radix2_pkg;

  // Widest index the helpers handle; LOG2_N_MAX must not exceed this.
  localparam int unsigned MAX_IDX_W = 16;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  // Reverse the low n bits of k; bits at and above n come back as zero.
  function automatic logic [MAX_IDX_W-1:0] bitrev(input logic [MAX_IDX_W-1:0] k,
                                                  input int unsigned n);
    logic [MAX_IDX_W-1:0] r;
    logic [MAX_IDX_W-1:0] bit_v;
    r = '0;
    for (int unsigned i = 0; i < MAX_IDX_W; i++) begin
      if (i < n) begin
        bit_v = (k >> (n - 1 - i)) & MAX_IDX_W'(1);
        r     = r | (bit_v << i);
      end
    end
    return r;
  endfunction

  // Zero or oversized lengths fall back to the largest supported frame.
  function automatic int unsigned clamp_log2n(input int unsigned cfg,
                                              input int unsigned max_log2n);
    return ((cfg == 0) || (cfg > max_log2n)) ? max_log2n : cfg;
  endfunction

  // Index of the last sample (N-1) of a frame of 2^n samples.
  function automatic logic [MAX_IDX_W-1:0] last_idx(input int unsigned n);
    return MAX_IDX_W'((32'd1 << n) - 32'd1);
  endfunction

endpackage

// File: rtl/dif_radix2_dpram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// output that only updates when a read is enabled (holds otherwise).
module dif_radix2_dpram #(
  parameter int unsigned DATA_W = 34,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [0:(1 << ADDR_W)-1];
  logic [DATA_W-1:0] r_rd_data;

  // Write port.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read; output holds while the port is idle.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dif_radix2_reorder_buf.sv
// Radix-2 DIF output reorder buffer: accepts bit-reversed FFT samples and
// emits them in natural order through a valid/ready port, using two
// ping-pong banks with per-bank frame length.
// Optional: define DIF_REORDER_STATS_EN to add the drop_cnt output.
module dif_radix2_reorder_buf
  import dif_radix2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 17,
  parameter int unsigned LOG2_N_MAX = 6,
  parameter int unsigned CFG_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CFG_W-1:0]      cfg_log2n,
  input  logic [DATA_WIDTH-1:0] din_re,
  input  logic [DATA_WIDTH-1:0] din_im,
  input  logic                  din_valid,
  output logic [DATA_WIDTH-1:0] dout_re,
  output logic [DATA_WIDTH-1:0] dout_im,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_sof,
  output logic                  dout_eof,
  output logic                  overflow
`ifdef DIF_REORDER_STATS_EN
  ,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int unsigned AW = LOG2_N_MAX;
  localparam int unsigned LW = $clog2(LOG2_N_MAX + 1);
  localparam int unsigned WW = 2 * DATA_WIDTH;

  // Bank bookkeeping
  bank_state_t     r_bank_state [2];
  logic [LW-1:0]   r_bank_log2n [2];

  // Write side
  logic            r_wr_sel;
  logic            r_wr_drop;
  logic [AW-1:0]   r_wr_cnt;
  logic [LW-1:0]   r_wr_log2n;
  logic            r_overflow;
  logic            w_wr_first;
  logic            w_wr_free;
  logic            w_wr_accept;
  logic            w_wr_drop_now;
  logic            w_wr_en;
  logic            w_wr_last;
  logic [LW-1:0]   w_wr_log2n;
  logic [AW-1:0]   w_wr_addr;

  // Read side
  logic            r_rd_sel;
  logic            r_rd_active;
  logic [AW-1:0]   r_rd_addr;
  logic            w_adv;
  logic            w_rd_start;
  logic            w_issue;
  logic            w_rd_last;
  logic [AW-1:0]   w_rd_addr;

  // RAM-output stage and output register
  logic            r_s1_valid;
  logic            r_s1_sof;
  logic            r_s1_eof;
  logic            r_s1_bank;
  logic [WW-1:0]   w_rd_data [2];
  logic [WW-1:0]   w_s1_data;
  logic            r_out_valid;
  logic            r_out_sof;
  logic            r_out_eof;
  logic            r_out_bank;
  logic [DATA_WIDTH-1:0] r_out_re;
  logic [DATA_WIDTH-1:0] r_out_im;
  logic            w_eof_acc;

  // Write-side decode: frame start, target-bank availability, address.
  always_comb begin
    w_wr_first    = din_valid && (r_wr_cnt == '0);
    w_wr_log2n    = w_wr_first ? LW'(clamp_log2n(32'(cfg_log2n), LOG2_N_MAX))
                               : r_wr_log2n;
    // A bank whose eof beat is being accepted right now counts as free.
    w_wr_free     = (r_bank_state[r_wr_sel] == BANK_EMPTY) ||
                    ((r_bank_state[r_wr_sel] == BANK_DRAINING) && w_eof_acc &&
                     (r_out_bank == r_wr_sel));
    w_wr_accept   = w_wr_first && w_wr_free;
    w_wr_drop_now = w_wr_first && !w_wr_free;
    w_wr_en       = w_wr_accept || (din_valid && !w_wr_first && !r_wr_drop);
    w_wr_last     = din_valid && (r_wr_cnt == AW'(last_idx(32'(w_wr_log2n))));
    w_wr_addr     = AW'(bitrev(MAX_IDX_W'(r_wr_cnt), 32'(w_wr_log2n)));
  end

  // Write counter, frame length latch, drop flag and bank pointer.
  // Dropped frames keep the pointer so accepted frames always alternate banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_cnt   <= '0;
      r_wr_log2n <= '0;
      r_wr_sel   <= 1'b0;
      r_wr_drop  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_wr_drop_now;
      if (din_valid) begin
        if (w_wr_first) begin
          r_wr_log2n <= w_wr_log2n;
          r_wr_drop  <= !w_wr_free;
        end
        if (w_wr_last) begin
          r_wr_cnt <= '0;
          if (!r_wr_drop) begin
            r_wr_sel <= ~r_wr_sel;
          end
        end else begin
          r_wr_cnt <= r_wr_cnt + AW'(1);
        end
      end
    end
  end

  // Per-bank frame length, captured when a frame is accepted into the bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank_log2n[0] <= '0;
      r_bank_log2n[1] <= '0;
    end else if (w_wr_accept) begin
      r_bank_log2n[r_wr_sel] <= w_wr_log2n;
    end
  end

  // Per-bank state machines.
  for (genvar gb = 0; gb < 2; gb++) begin : g_bank_fsm
    bank_state_t w_state_nxt;

    // Next-state: a fresh frame wins over the same-cycle return to EMPTY.
    always_comb begin
      w_state_nxt = r_bank_state[gb];
      if (w_wr_accept && (r_wr_sel == 1'(gb))) begin
        w_state_nxt = BANK_FILLING;
      end else if (w_wr_en && w_wr_last && (r_wr_sel == 1'(gb))) begin
        w_state_nxt = BANK_FULL;
      end else if (w_rd_start && (r_rd_sel == 1'(gb))) begin
        w_state_nxt = BANK_DRAINING;
      end else if (w_eof_acc && (r_out_bank == 1'(gb))) begin
        w_state_nxt = BANK_EMPTY;
      end
    end

    // State register.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_bank_state[gb] <= BANK_EMPTY;
      end else begin
        r_bank_state[gb] <= w_state_nxt;
      end
    end
  end

  // Read-side decode: the whole read pipeline advances together when the
  // output register is empty or being consumed.
  always_comb begin
    w_adv      = !r_out_valid || dout_ready;
    w_rd_start = !r_rd_active && (r_bank_state[r_rd_sel] == BANK_FULL) && w_adv;
    w_issue    = w_rd_start || (r_rd_active && w_adv);
    w_rd_addr  = r_rd_active ? r_rd_addr : '0;
    w_rd_last  = (w_rd_addr == AW'(last_idx(32'(r_bank_log2n[r_rd_sel]))));
    w_eof_acc  = r_out_valid && dout_ready && r_out_eof;
    w_s1_data  = w_rd_data[r_s1_bank];
  end

  // Sequential read address; hands over to the other bank after N-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_sel    <= 1'b0;
      r_rd_active <= 1'b0;
      r_rd_addr   <= '0;
    end else if (w_issue) begin
      if (w_rd_last) begin
        r_rd_active <= 1'b0;
        r_rd_addr   <= '0;
        r_rd_sel    <= ~r_rd_sel;
      end else begin
        r_rd_active <= 1'b1;
        r_rd_addr   <= w_rd_addr + AW'(1);
      end
    end
  end

  // RAM-output tag stage and output register; both hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_sof    <= 1'b0;
      r_s1_eof    <= 1'b0;
      r_s1_bank   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eof   <= 1'b0;
      r_out_bank  <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
    end else if (w_adv) begin
      r_s1_valid  <= w_issue;
      r_s1_sof    <= w_issue && !r_rd_active;
      r_s1_eof    <= w_issue && w_rd_last;
      r_s1_bank   <= r_rd_sel;
      r_out_valid <= r_s1_valid;
      r_out_sof   <= r_s1_valid && r_s1_sof;
      r_out_eof   <= r_s1_valid && r_s1_eof;
      if (r_s1_valid) begin
        r_out_bank <= r_s1_bank;
        r_out_re   <= w_s1_data[WW-1:DATA_WIDTH];
        r_out_im   <= w_s1_data[DATA_WIDTH-1:0];
      end
    end
  end

  // Sample storage, one RAM per bank.
  for (genvar gb = 0; gb < 2; gb++) begin : g_bank_ram
    dif_radix2_dpram #(
      .DATA_W (WW),
      .ADDR_W (AW)
    ) u_ram (
      .i_clk     (clk),
      .i_wr_en   (w_wr_en && (r_wr_sel == 1'(gb))),
      .i_wr_addr (w_wr_addr),
      .i_wr_data ({din_re, din_im}),
      .i_rd_en   (w_issue && (r_rd_sel == 1'(gb))),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd_data[gb])
    );
  end

`ifdef DIF_REORDER_STATS_EN
  logic [15:0] r_drop_cnt;

  // Saturating count of dropped frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_wr_drop_now && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign dout_re    = r_out_re;
  assign dout_im    = r_out_im;
  assign dout_valid = r_out_valid;
  assign dout_sof   = r_out_sof;
  assign dout_eof   = r_out_eof;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_dif_radix2_reorder_buf.sv
// Directed bench for dif_radix2_reorder_buf: bit-reversed frames in,
// natural-order beats checked against a queue of expected beats.
module tb_dif_radix2_reorder_buf;

  localparam int DW   = 17;
  localparam int LMAX = 6;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] cfg_log2n;
  logic [DW-1:0] din_re;
  logic [DW-1:0] din_im;
  logic          din_valid;
  logic [DW-1:0] dout_re;
  logic [DW-1:0] dout_im;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic          dout_sof;
  logic          dout_eof;
  logic          overflow;
`ifdef DIF_REORDER_STATS_EN
  logic [15:0]   drop_cnt;
`endif

  dif_radix2_reorder_buf #(
    .DATA_WIDTH (DW),
    .LOG2_N_MAX (LMAX),
    .CFG_W      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_log2n  (cfg_log2n),
    .din_re     (din_re),
    .din_im     (din_im),
    .din_valid  (din_valid),
    .dout_re    (dout_re),
    .dout_im    (dout_im),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_sof   (dout_sof),
    .dout_eof   (dout_eof),
    .overflow   (overflow)
`ifdef DIF_REORDER_STATS_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ovf_cnt = 0;
  int gap_cnt = 0;
  int extra_cnt = 0;
  logic [35:0] sb[$];
  int sof_cyc[$];
  int eof_cyc[$];
  bit rand_mode = 1'b0;
  bit ready_fix = 1'b1;
  bit hold_vld  = 1'b0;
  logic [36:0] hold_val;
  bit in_frame  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int tb_bitrev(input int k, input int nb);
    int r = 0;
    for (int i = 0; i < nb; i++) begin
      if ((k & (1 << i)) != 0) r = r | (1 << (nb - 1 - i));
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] mk_re(input int tag, input int idx);
    return DW'(tag * 256 + idx);
  endfunction

  function automatic logic [DW-1:0] mk_im(input int tag, input int idx);
    return DW'((tag * 1000 + idx * 3) ^ 32'h1A5A5);
  endfunction

  function automatic logic [35:0] beat(input int tag, input int idx, input bit sof, input bit eof);
    return {sof, eof, mk_re(tag, idx), mk_im(tag, idx)};
  endfunction

  // Drives one frame in bit-reversed order; abort_at >= 0 stops early.
  task automatic send_frame(input int cfg, input int eff, input int tag,
                            input bit exp_drop, input int abort_at);
    int n;
    int idx;
    n = 1 << eff;
    for (int k = 0; k < n; k++) begin
      if (k == abort_at) return;
      idx = tb_bitrev(k, eff);
      @(posedge clk); #1;
      din_valid = 1'b1;
      cfg_log2n = (k == 0) ? CW'(cfg) : CW'(k % 8);
      din_re    = mk_re(tag, idx);
      din_im    = mk_im(tag, idx);
    end
    if (!exp_drop) begin
      for (int j = 0; j < n; j++) sb.push_back(beat(tag, j, j == 0, j == n - 1));
    end
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(posedge clk); #1;
      din_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int i = 0;
    while (sb.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, 64'(sb.size()), 64'd0);
    repeat (4) @(posedge clk);
  endtask

  always @(posedge clk) cyc++;

  // Ready generator: fixed level or 50% random.
  always @(posedge clk) begin
    #1;
    dout_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  // Output monitor: scoreboard, stall stability, intra-frame gaps, overflow.
  always @(negedge clk) begin
    if (rst) begin
      hold_vld = 1'b0;
      in_frame = 1'b0;
    end else begin
      if (overflow) ovf_cnt++;
      if (hold_vld)
        check("stall_hold", 64'({dout_valid, dout_sof, dout_eof, dout_re, dout_im}), 64'(hold_val));
      if (in_frame && dout_ready && !dout_valid) gap_cnt++;
      if (dout_valid && dout_ready) begin
        if (sb.size() == 0) extra_cnt++;
        else check("beat", 64'({dout_sof, dout_eof, dout_re, dout_im}), 64'(sb.pop_front()));
        if (dout_sof) begin
          sof_cyc.push_back(cyc);
          in_frame = 1'b1;
        end
        if (dout_eof) begin
          eof_cyc.push_back(cyc);
          in_frame = 1'b0;
        end
      end
      hold_vld = dout_valid && !dout_ready;
      hold_val = {dout_valid, dout_sof, dout_eof, dout_re, dout_im};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1);
  end

  initial begin
    int ovf0;
    rst = 1'b1; din_valid = 1'b0; cfg_log2n = '0; din_re = '0; din_im = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(dout_valid), 64'd0);
    check("rst_sof",   64'(dout_sof),   64'd0);
    check("rst_eof",   64'(dout_eof),   64'd0);
    check("rst_ovf",   64'(overflow),   64'd0);
    check("rst_re",    64'(dout_re),    64'd0);
    check("rst_im",    64'(dout_im),    64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 64-point frame, first-beat latency of two cycles after sample 63
    send_frame(6, 6, 1, 1'b0, -1);
    @(posedge clk); #1;
    din_valid = 1'b0;
    @(negedge clk); check("lat_c1", 64'(dout_valid), 64'd0);
    @(negedge clk); check("lat_c2", 64'(dout_valid), 64'd0);
    @(negedge clk); check("lat_c3", 64'(dout_valid), 64'd1);
    check("lat_sof", 64'(dout_sof), 64'd1);
    wait_drain("drain_n64", 200);

    // 8, 64, 16 back to back; the 64 and 16 frames must abut at the output
    sof_cyc.delete(); eof_cyc.delete();
    send_frame(3, 3, 2, 1'b0, -1);
    send_frame(6, 6, 3, 1'b0, -1);
    send_frame(4, 4, 4, 1'b0, -1);
    idle(1);
    wait_drain("drain_b2b", 400);
    check("b2b_frames", 64'(sof_cyc.size()), 64'd3);
    check("b2b_abut", 64'(sof_cyc[2]), 64'(eof_cyc[1] + 1));

    // Output stalled for 200 cycles while three 32-point frames arrive
    ready_fix = 1'b0;
    @(posedge clk);
    ovf0 = ovf_cnt;
    send_frame(5, 5, 5, 1'b0, -1);
    send_frame(5, 5, 6, 1'b0, -1);
    send_frame(5, 5, 7, 1'b1, -1);
    idle(104);
    ready_fix = 1'b1;
    wait_drain("drain_ovf", 400);
    check("ovf_once", 64'(ovf_cnt - ovf0), 64'd1);
`ifdef DIF_REORDER_STATS_EN
    check("drop_cnt", 64'(drop_cnt), 64'd1);
`endif

    // Random 50% ready
    rand_mode = 1'b1;
    ovf0 = ovf_cnt;
    send_frame(4, 4, 8, 1'b0, -1);
    send_frame(6, 6, 9, 1'b0, -1);
    idle(1);
    wait_drain("drain_rand1", 1000);
    send_frame(3, 3, 10, 1'b0, -1);
    send_frame(5, 5, 11, 1'b0, -1);
    idle(1);
    wait_drain("drain_rand2", 1000);
    rand_mode = 1'b0;
    check("rand_no_ovf", 64'(ovf_cnt - ovf0), 64'd0);

    // Out-of-range lengths handled as 64 points
    send_frame(7, 6, 12, 1'b0, -1);
    idle(1);
    wait_drain("drain_cfg7", 200);
    send_frame(0, 6, 13, 1'b0, -1);
    idle(1);
    wait_drain("drain_cfg0", 200);

    // Reset in place of input sample 20 while a frame is draining
    ovf0 = ovf_cnt;
    send_frame(6, 6, 14, 1'b0, -1);
    send_frame(6, 6, 15, 1'b1, 20);
    @(posedge clk); #1;
    din_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk); check("prerst_valid", 64'(dout_valid), 64'd1);
    @(negedge clk);
    check("mrst_valid", 64'(dout_valid), 64'd0);
    check("mrst_sof",   64'(dout_sof),   64'd0);
    check("mrst_eof",   64'(dout_eof),   64'd0);
    check("mrst_re",    64'(dout_re),    64'd0);
    check("mrst_im",    64'(dout_im),    64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame(6, 6, 16, 1'b0, -1);
    idle(1);
    wait_drain("drain_postrst", 200);
    check("postrst_no_ovf", 64'(ovf_cnt - ovf0), 64'd0);

    check("extra_beats", 64'(extra_cnt), 64'd0);
    check("gaps", 64'(gap_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
